mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive data grants while a fetch request waits.
REQ-002 clk_i  in  1  clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 imem_req_i  in  1  fetch request; held until imem_gnt_o.
REQ-005 imem_addr_i  in  32  fetch address.
REQ-006 imem_gnt_o  out  1  fetch request accepted by memory.
REQ-007 imem_rvalid_o  out  1  fetch response valid.
REQ-008 imem_rdata_o  out  32  fetch response instruction.
REQ-009 dmem_req_i  in  1  load/store request; held until dmem_gnt_o.
REQ-010 dmem_we_i  in  1  1 = store, 0 = load.
REQ-011 dmem_be_i  in  4  store byte enables.
REQ-012 dmem_addr_i  in  32  data address.
REQ-013 dmem_wdata_i  in  32  store data.
REQ-014 dmem_gnt_o  out  1  data request accepted by memory.
REQ-015 dmem_rvalid_o  out  1  data response valid (loads and stores).
REQ-016 dmem_rdata_o  out  32  load data.
REQ-017 mem_req_o, mem_we_o, mem_be_o[3:0], mem_addr_o[31:0], mem_wdata_o[31:0]  out  shared memory request port.
REQ-018 mem_gnt_i  in  1  memory accepts mem_req_o this cycle.
REQ-019 mem_rvalid_i  in  1 and mem_rdata_i  in  32  memory response.

Function
REQ-020 FSM states IDLE, REQ, WAIT; at most one transaction outstanding.
REQ-021 IDLE, no request: stay IDLE, mem_req_o = 0.
REQ-022 IDLE, request(s) present: select owner, register owner, we, be, addr, wdata into request registers; next cycle state REQ, mem_req_o = 1 (one-cycle arbitration latency).
REQ-023 Selection: dmem only -> dmem; imem only -> imem; both -> dmem unless streak counter == STARVE_LIMIT, then imem.
REQ-024 Fetch owner drives mem_we_o = 0, mem_be_o = 4'b1111, mem_wdata_o = 0.
REQ-025 Streak counter: +1 on each dmem selection with imem_req_i = 1; cleared on imem selection or on dmem selection with imem_req_i = 0; saturates at STARVE_LIMIT.
REQ-026 REQ: mem_req_o and request registers held stable until mem_gnt_i = 1.
REQ-027 REQ with mem_gnt_i = 1: owner's gnt_o = 1 combinationally that cycle, other gnt_o = 0; next state WAIT, mem_req_o = 0 next cycle.
REQ-028 REQ with mem_gnt_i = 1 and mem_rvalid_i = 1 same cycle: gnt and rvalid both delivered to owner that cycle; next state IDLE.
REQ-029 WAIT: on mem_rvalid_i = 1, owner's rvalid_o = 1 combinationally, rdata_o = mem_rdata_i; next state IDLE.
REQ-030 imem_rdata_o and dmem_rdata_o always driven from mem_rdata_i; non-owner rvalid_o = 0.
REQ-031 mem_gnt_i outside REQ and mem_rvalid_i in IDLE ignored, no output effect.
REQ-032 Transaction completion always returns to IDLE; minimum 1 idle cycle between consecutive mem_req_o pulses.
REQ-033 Requester deasserting req_i before its gnt_o is a protocol violation; arbiter completes the registered transaction regardless.

Reset
REQ-034 rst_i = 1 asynchronously forces state IDLE, streak counter 0, request registers 0.
REQ-035 During reset all outputs 0: mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, both gnt_o, both rvalid_o.
REQ-036 Reset mid-transaction (REQ or WAIT) abandons it; no gnt/rvalid issued afterward for it; first post-reset cycle is IDLE.

Verification
REQ-037 imem_req_i=1, addr 0x0000_0010, mem_gnt_i=1 at first REQ cycle, mem_rvalid_i=1 two cycles later with 0x0051_3093 -> mem_req_o high 1 cycle at addr 0x10, imem_gnt_o 1 cycle, imem_rvalid_o with rdata 0x0051_3093, dmem outputs 0.
REQ-038 imem and dmem req same cycle, dmem store addr 0x100 wdata 0xDEAD_BEEF be 4'b0011 -> dmem served first with mem_we_o=1, be 0011; imem served in next transaction.
REQ-039 imem_req_i held, dmem_req_i held continuously, STARVE_LIMIT=4 -> exactly 4 dmem grants then 1 imem grant, pattern repeats.
REQ-040 mem_gnt_i held 0 for 5 cycles in REQ -> mem_req_o, mem_addr_o, mem_we_o stable all 5 cycles; no gnt_o.
REQ-041 mem_gnt_i and mem_rvalid_i together in REQ -> owner gnt_o and rvalid_o same cycle, IDLE next cycle.
REQ-042 rst_i pulsed in WAIT, then mem_rvalid_i=1 -> no rvalid_o asserted, all outputs 0, streak counter 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Purpose : arbitrates a fetch port and a load/store port onto one shared memory port, with a
//           single outstanding transaction and a fetch anti-starvation limit.
// Latency : one cycle arbitration (IDLE -> REQ); grant and response pass through combinationally.
// Backpressure: the request is held in REQ until mem_gnt_i; a requester keeps req asserted until its gnt.
//
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   imem_req_i/addr_i -> gnt/rvalid/rdata_o            fetch side (read-only, full-word)
//   dmem_req/we/be/addr/wdata_i -> gnt/rvalid/rdata_o  load/store side
//   mem_req/we/be/addr/wdata_o, mem_gnt_i, mem_rvalid_i, mem_rdata_i   shared memory port
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        imem_req_i,
    input  logic [31:0] imem_addr_i,
    output logic        imem_gnt_o,
    output logic        imem_rvalid_o,
    output logic [31:0] imem_rdata_o,

    input  logic        dmem_req_i,
    input  logic        dmem_we_i,
    input  logic [3:0]  dmem_be_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    output logic        dmem_gnt_o,
    output logic        dmem_rvalid_o,
    output logic [31:0] dmem_rdata_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    // +2 keeps the counter at least one bit wide even for STARVE_LIMIT = 0.
    localparam int CW = $clog2(STARVE_LIMIT + 2);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          state;
    logic            owner_dmem;   // 1 = load/store owns the transaction, 0 = fetch
    logic            req_we;
    logic [3:0]      req_be;
    logic [31:0]     req_addr;
    logic [31:0]     req_wdata;
    logic [CW-1:0]   streak;       // consecutive data wins while a fetch was waiting

    logic            pick_dmem;
    logic            pick_imem;
    logic            txn_gnt;
    logic            txn_rvalid;

    // Data normally wins; once the streak hits the limit a waiting fetch goes first.
    always_comb begin
        pick_dmem = dmem_req_i && !(imem_req_i && (streak == LIMIT));
        pick_imem = imem_req_i && !pick_dmem;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            owner_dmem <= 1'b0;
            req_we     <= 1'b0;
            req_be     <= 4'b0000;
            req_addr   <= 32'h0;
            req_wdata  <= 32'h0;
            streak     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_dmem) begin
                        owner_dmem <= 1'b1;
                        req_we     <= dmem_we_i;
                        req_be     <= dmem_be_i;
                        req_addr   <= dmem_addr_i;
                        req_wdata  <= dmem_wdata_i;
                        state      <= REQ;
                        if (!imem_req_i)
                            streak <= '0;
                        else if (streak != LIMIT)
                            streak <= streak + 1'b1;
                    end else if (pick_imem) begin
                        owner_dmem <= 1'b0;
                        req_we     <= 1'b0;
                        req_be     <= 4'b1111;
                        req_addr   <= imem_addr_i;
                        req_wdata  <= 32'h0;
                        state      <= REQ;
                        streak     <= '0;
                    end
                end
                REQ: begin
                    // A same-cycle response skips WAIT entirely.
                    if (mem_gnt_i)
                        state <= mem_rvalid_i ? IDLE : WAIT;
                end
                WAIT: begin
                    if (mem_rvalid_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Grant and response are only meaningful inside a transaction; stray
    // mem_gnt_i / mem_rvalid_i in other states never reach a requester.
    always_comb begin
        txn_gnt    = (state == REQ) && mem_gnt_i;
        txn_rvalid = (txn_gnt || (state == WAIT)) && mem_rvalid_i;
    end

    assign mem_req_o     = (state == REQ);
    assign mem_we_o      = req_we;
    assign mem_be_o      = req_be;
    assign mem_addr_o    = req_addr;
    assign mem_wdata_o   = req_wdata;

    assign imem_gnt_o    = txn_gnt && !owner_dmem;
    assign dmem_gnt_o    = txn_gnt && owner_dmem;
    assign imem_rvalid_o = txn_rvalid && !owner_dmem;
    assign dmem_rvalid_o = txn_rvalid && owner_dmem;
    assign imem_rdata_o  = mem_rdata_i;
    assign dmem_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        imem_req_i = 1'b0;
    logic [31:0] imem_addr_i = '0;
    logic        imem_gnt_o, imem_rvalid_o;
    logic [31:0] imem_rdata_o;
    logic        dmem_req_i = 1'b0, dmem_we_i = 1'b0;
    logic [3:0]  dmem_be_i = '0;
    logic [31:0] dmem_addr_i = '0, dmem_wdata_i = '0;
    logic        dmem_gnt_o, dmem_rvalid_o;
    logic [31:0] dmem_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i),
        .imem_gnt_o(imem_gnt_o), .imem_rvalid_o(imem_rvalid_o), .imem_rdata_o(imem_rdata_o),
        .dmem_req_i(dmem_req_i), .dmem_we_i(dmem_we_i), .dmem_be_i(dmem_be_i),
        .dmem_addr_i(dmem_addr_i), .dmem_wdata_i(dmem_wdata_i),
        .dmem_gnt_o(dmem_gnt_o), .dmem_rvalid_o(dmem_rvalid_o), .dmem_rdata_o(dmem_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Transaction-level reference: a transaction is either absent, waiting to be
    // accepted, or accepted and waiting for its response.
    bit          m_busy = 1'b0;
    bit          m_acc  = 1'b0;
    bit          m_dmem = 1'b0;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    int          m_streak = 0;

    bit          exp_ig, exp_dg;
    logic [31:0] gseq;
    int          gcnt;

    task automatic step(input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dwe, input logic [3:0] dbe,
                        input logic [31:0] da, input logic [31:0] dwd,
                        input logic g, input logic rv, input logic [31:0] rd);
        bit e_req, e_g, e_rv, take_d;
        @(negedge clk_i);
        imem_req_i = ir;  imem_addr_i = ia;
        dmem_req_i = dr;  dmem_we_i = dwe; dmem_be_i = dbe;
        dmem_addr_i = da; dmem_wdata_i = dwd;
        mem_gnt_i = g;    mem_rvalid_i = rv; mem_rdata_i = rd;
        #1;
        e_req = m_busy && !m_acc;
        e_g   = e_req && g;
        e_rv  = m_busy && (m_acc || g) && rv;
        chk("mem_req", 32'(mem_req_o), 32'(e_req));
        if (e_req) begin
            chk("mem_addr", mem_addr_o, m_addr);
            chk("mem_we", 32'(mem_we_o), 32'(m_we));
            chk("mem_be", 32'(mem_be_o), 32'(m_be));
            chk("mem_wdata", mem_wdata_o, m_wdata);
        end
        exp_ig = e_g && !m_dmem;
        exp_dg = e_g && m_dmem;
        chk("imem_gnt", 32'(imem_gnt_o), 32'(exp_ig));
        chk("dmem_gnt", 32'(dmem_gnt_o), 32'(exp_dg));
        chk("imem_rvalid", 32'(imem_rvalid_o), 32'(e_rv && !m_dmem));
        chk("dmem_rvalid", 32'(dmem_rvalid_o), 32'(e_rv && m_dmem));
        chk("imem_rdata", imem_rdata_o, rd);
        chk("dmem_rdata", dmem_rdata_o, rd);
        if (dmem_gnt_o === 1'b1) begin gseq = {gseq[30:0], 1'b1}; gcnt++; end
        else if (imem_gnt_o === 1'b1) begin gseq = {gseq[30:0], 1'b0}; gcnt++; end
        // advance the reference for the coming clock edge
        if (!m_busy) begin
            if (ir || dr) begin
                take_d = dr && !(ir && m_streak == LIMIT);
                m_busy = 1'b1; m_acc = 1'b0; m_dmem = take_d;
                if (take_d) begin
                    m_we = dwe; m_be = dbe; m_addr = da; m_wdata = dwd;
                    m_streak = ir ? ((m_streak < LIMIT) ? m_streak + 1 : LIMIT) : 0;
                end else begin
                    m_we = 1'b0; m_be = 4'hF; m_addr = ia; m_wdata = 32'h0;
                    m_streak = 0;
                end
            end
        end else if (!m_acc) begin
            if (g) begin
                if (rv) m_busy = 1'b0;
                else    m_acc  = 1'b1;
            end
        end else if (rv) begin
            m_busy = 1'b0;
        end
    endtask

    // Reset with noisy inputs: everything must read zero and any open transaction is dropped.
    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
        #1;
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_mem_we", 32'(mem_we_o), 32'd0);
        chk("rst_mem_be", 32'(mem_be_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_wdata", mem_wdata_o, 32'd0);
        chk("rst_gnt", 32'({imem_gnt_o, dmem_gnt_o}), 32'd0);
        chk("rst_rvalid", 32'({imem_rvalid_o, dmem_rvalid_o}), 32'd0);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        m_busy = 1'b0; m_acc = 1'b0; m_streak = 0;
    endtask

    bit          i_pend, d_pend;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        d_we;
    logic [3:0]  d_be;
    logic        g, rv;

    initial begin
        do_reset();

        // single fetch: granted at first REQ cycle, response two cycles later
        step(1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        step(1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0);
        step(0, 32'h0,  0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        step(0, 32'h0,  0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h0051_3093);
        step(0, 32'h0,  0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);

        // simultaneous requests: store first, then fetch with same-cycle gnt+rvalid
        step(1, 32'h40, 1, 1, 4'b0011, 32'h100, 32'hDEAD_BEEF, 0, 0, 32'h0);
        step(1, 32'h40, 1, 1, 4'b0011, 32'h100, 32'hDEAD_BEEF, 1, 0, 32'h0);
        step(1, 32'h40, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h1);
        step(1, 32'h40, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        step(1, 32'h40, 0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 32'h2);
        step(0, 32'h0,  0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);

        // memory stalls the grant for five cycles, request must stay put
        step(0, 32'h0, 1, 0, 4'hF, 32'h200, 32'h0, 0, 0, 32'h0);
        for (int i = 0; i < 5; i++)
            step(0, 32'h0, 1, 0, 4'hF, 32'h200, 32'h0, 0, 0, 32'h0);
        step(0, 32'h0, 1, 0, 4'hF, 32'h200, 32'h0, 1, 1, 32'h3);

        // reset while waiting for a response; late response must be dropped
        step(0, 32'h0, 1, 0, 4'hF, 32'h300, 32'h0, 0, 0, 32'h0);
        step(0, 32'h0, 1, 0, 4'hF, 32'h300, 32'h0, 1, 0, 32'h0);
        do_reset();
        step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h4);
        step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 32'h5);

        // both held with an always-ready memory: D D D D I repeating (streak restarts at 0)
        gseq = '0; gcnt = 0;
        for (int i = 0; i < 20; i++)
            step(1, 32'h80, 1, 0, 4'hF, 32'h400, 32'h0, 1, 1, 32'h6);
        chk("starve_count", 32'(gcnt), 32'd10);
        chk("starve_pattern", gseq, 32'b11110_11110);
        step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);

        // randomized traffic with occasional resets
        i_pend = 0; d_pend = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_we = 0; d_be = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!i_pend && ($urandom % 3 == 0)) begin
                i_pend = 1; i_addr = $urandom;
            end
            if (!d_pend && ($urandom % 2 == 0)) begin
                d_pend = 1; d_addr = $urandom; d_wdata = $urandom;
                d_we = 1'($urandom); d_be = 4'($urandom);
            end
            g = 1'($urandom);
            if (m_busy && (m_acc || g)) rv = ($urandom % 3 == 0);
            else if (!m_busy)           rv = 1'($urandom);
            else                        rv = 1'b0;
            step(i_pend, i_addr, d_pend, d_we, d_be, d_addr, d_wdata, g, rv, $urandom);
            if (exp_ig) i_pend = 0;
            if (exp_dg) d_pend = 0;
            if ($urandom % 400 == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
